// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin arbiter sharing one FIFO write port
//
// Purpose: selects one of NUM_REQ valid/ready beat sources per cycle and
// registers the winning beat into a single output stage that drives the
// FIFO upstr_d_valid / upstr_data / upstr_d_ready handshake.
//
// Optional feature: define ARB_PKT_LOCK_EN to hold the grant on one requester
// from a beat with EOP=0 until its beat with EOP=1 (bit DATA_W-1).
//
// Ports:
//   clk        in   clock, rising edge
//   nrst       in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]         per-requester beat valid
//   req_data   in   [NUM_REQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]         per-requester accept, one-hot or zero
//   out_valid  out                    to FIFO upstr_d_valid
//   out_data   out  [DATA_W]          to FIFO upstr_data
//   out_ready  in                     from FIFO upstr_d_ready
//   grant_id   out  [ID_W]            source of the beat in the output stage
//   busy       out                    output stage full or packet lock held

module fifo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 33,
    parameter int ID_W    = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    input  logic                        out_ready,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [ID_W-1:0]   grant_id_q,  grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t            state_q, state_d;
    logic [ID_W-1:0]   lock_id_q, lock_id_d;
`endif

    logic               load_en;
    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    sel_next;
    logic [DATA_W-1:0]  beat;

    always_comb begin
        // Output stage is free when empty or being drained this cycle.
        load_en = !out_valid_q || out_ready;

`ifdef ARB_PKT_LOCK_EN
        if (state_q == LOCKED) begin
            cand = req_valid & (NUM_REQ'(1) << lock_id_q);
        end else begin
            cand = req_valid;
        end
`else
        cand = req_valid;
`endif

        // Two passes: first the candidates at or above rr_ptr, then the
        // wrapped ones below it; the first hit is the round-robin winner.
        found = 1'b0;
        sel   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && cand[j] && (ID_W'(j) >= rr_ptr_q)) begin
                found = 1'b1;
                sel   = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && cand[j]) begin
                found = 1'b1;
                sel   = ID_W'(j);
            end
        end

        sel_next = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);

        beat = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (sel == ID_W'(j)) begin
                beat = req_data[j*DATA_W +: DATA_W];
            end
        end

        req_ready = '0;
        if (nrst && load_en && found) begin
            req_ready = NUM_REQ'(1) << sel;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef ARB_PKT_LOCK_EN
        state_d     = state_q;
        lock_id_d   = lock_id_q;
`endif

        if (load_en) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = beat;
                grant_id_d  = sel;
                rr_ptr_d    = sel_next;
`ifdef ARB_PKT_LOCK_EN
                if (state_q == IDLE) begin
                    // Start of a multi-beat packet: pin the grant, keep rr_ptr.
                    if (!beat[DATA_W-1]) begin
                        state_d   = LOCKED;
                        lock_id_d = sel;
                        rr_ptr_d  = rr_ptr_q;
                    end
                end else if (beat[DATA_W-1]) begin
                    // sel equals lock_id here, so sel_next is lock_id+1.
                    state_d = IDLE;
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
`ifdef ARB_PKT_LOCK_EN
            state_q     <= IDLE;
            lock_id_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_PKT_LOCK_EN
            state_q     <= state_d;
            lock_id_q   <= lock_id_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant_id  = grant_id_q;
`ifdef ARB_PKT_LOCK_EN
    assign busy      = out_valid_q || (state_q == LOCKED);
`else
    assign busy      = out_valid_q;
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - self-checking bench for fifo_rr_arbiter

module tb_fifo_rr_arbiter;

    localparam int NR = 4;
    localparam int DW = 33;

    logic              clk;
    logic              nrst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic [1:0]        grant_id;
    logic              busy;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    id;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    fifo_rr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_W(2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [DW-1:0] d, input logic [1:0] id);
        exp_t e;
        e.data = d;
        e.id   = id;
        return e;
    endfunction

    task automatic set_beat(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        nrst      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        req_valid = 4'hF;
        out_ready = 1'b1;
        sb.delete();
        #2;
        n_checks++;
        if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin
            $display("FAIL reset_hold: req_ready=%b out_valid=%b expected 0000/0", req_ready, out_valid);
        end else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        nrst      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, req_ready, grant_id, busy} !== 8'b0) begin
                $display("FAIL reset_idle: cycle %0d out_valid=%b req_ready=%b grant_id=%0d busy=%b expected all 0",
                         c, out_valid, req_ready, grant_id, busy);
            end else n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_beat(i, {1'b1, 32'hA000_0000 + 32'(i)});
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) sb.push_back(mk({1'b1, 32'hA000_0000 + 32'(k % 4)}, 2'(k % 4)));
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0001) begin
            $display("FAIL contention_first: out_valid=%b req_ready=%b expected 0/0001", out_valid, req_ready);
        end else n_pass++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            e = sb.pop_front();
            if (out_valid !== 1'b1 || out_data !== e.data || grant_id !== e.id) begin
                $display("FAIL contention_beat%0d: valid=%b data=%h id=%0d expected 1/%h/%0d",
                         k, out_valid, out_data, grant_id, e.data, e.id);
            end else n_pass++;
        end
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    task automatic test_backpressure();
        int   idx;
        logic acc;
        logic stalled;
        do_reset();
        for (int k = 0; k < 8; k++) sb.push_back(mk({1'b1, 32'(k + 1)}, 2'd2));
        idx = 0;
        acc = 1'b0;
        for (int cyc = 0; cyc < 80 && sb.size() > 0; cyc++) begin
            if (acc) idx++;
            out_ready = (cyc % 3 == 0);
            req_valid = (idx < 8) ? 4'b0100 : 4'b0000;
            set_beat(2, {1'b1, 32'(idx + 1)});
            @(negedge clk);
            stalled = out_valid && !out_ready;
            if (idx < 8) begin
                n_checks++;
                if (req_ready !== (stalled ? 4'b0000 : 4'b0100)) begin
                    $display("FAIL bp_ready: cycle %0d req_ready=%b expected %b", cyc, req_ready,
                             stalled ? 4'b0000 : 4'b0100);
                end else n_pass++;
            end
            if (out_valid && sb.size() > 0) begin
                n_checks++;
                if (out_data !== sb[0].data || grant_id !== sb[0].id) begin
                    $display("FAIL bp_data: cycle %0d data=%h id=%0d expected %h/%0d",
                             cyc, out_data, grant_id, sb[0].data, sb[0].id);
                end else n_pass++;
                if (out_ready) void'(sb.pop_front());
            end
            acc = req_valid[2] && req_ready[2];
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL bp_timeout: %0d beats outstanding expected 0", sb.size());
        end else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_rr_skip();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        set_beat(0, 33'h1_0000_0010);
        set_beat(3, 33'h1_0000_0033);
        req_valid = 4'b0001;
        sb.push_back(mk(33'h1_0000_0010, 2'd0));
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL rr_prime: req_ready=%b expected 0001", req_ready);
        end else n_pass++;
        @(posedge clk);
        #1;
        set_beat(0, 33'h1_0000_0020);
        req_valid = 4'b1001;
        sb.push_back(mk(33'h1_0000_0033, 2'd3));
        sb.push_back(mk(33'h1_0000_0020, 2'd0));
        sb.push_back(mk(33'h1_0000_0033, 2'd3));
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                n_checks++;
                if (req_ready !== 4'b1000) begin
                    $display("FAIL rr_skip_first: req_ready=%b expected 1000", req_ready);
                end else n_pass++;
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (out_data !== e.data || grant_id !== e.id) begin
                    $display("FAIL rr_skip_beat: data=%h id=%0d expected %h/%0d", out_data, grant_id, e.data, e.id);
                end else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL rr_skip_timeout: %0d beats outstanding expected 0", sb.size());
        end else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_lock();
        exp_t e;
        int   idx;
        logic acc;
        do_reset();
        out_ready = 1'b1;
        set_beat(0, 33'h1_0000_00A0);
        req_valid = 4'b0001;
        sb.push_back(mk(33'h1_0000_00A0, 2'd0));
        @(posedge clk);
        #1;
`ifdef ARB_PKT_LOCK_EN
        sb.push_back(mk(33'h0_0000_0011, 2'd1));
        sb.push_back(mk(33'h0_0000_0012, 2'd1));
        sb.push_back(mk(33'h1_0000_0013, 2'd1));
        sb.push_back(mk(33'h1_0000_00A0, 2'd0));
`else
        sb.push_back(mk(33'h0_0000_0011, 2'd1));
        sb.push_back(mk(33'h1_0000_00A0, 2'd0));
        sb.push_back(mk(33'h0_0000_0012, 2'd1));
        sb.push_back(mk(33'h1_0000_00A0, 2'd0));
        sb.push_back(mk(33'h1_0000_0013, 2'd1));
`endif
        idx = 0;
        acc = 1'b0;
        for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
            if (acc) idx++;
            req_valid = {2'b00, (idx < 3), 1'b1};
            set_beat(1, {(idx == 2), 32'h11 + 32'(idx)});
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                n_checks++;
                if (out_data !== e.data || grant_id !== e.id) begin
                    $display("FAIL lock_order: cycle %0d data=%h id=%0d expected %h/%0d",
                             cyc, out_data, grant_id, e.data, e.id);
                end else n_pass++;
            end
            acc = req_valid[1] && req_ready[1];
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL lock_timeout: %0d beats outstanding expected 0", sb.size());
        end else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        set_beat(1, 33'h0_0000_0021);
        @(posedge clk);
        #1 set_beat(1, 33'h0_0000_0022);
        @(posedge clk);
        #1 req_valid = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 33'h0_0000_0022 || grant_id !== 2'd1) begin
            $display("FAIL mid_beat2: valid=%b data=%h id=%0d expected 1/000000022/1", out_valid, out_data, grant_id);
        end else n_pass++;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin
            $display("FAIL mid_async: valid=%b busy=%b req_ready=%b id=%0d expected 0/0/0000/0",
                     out_valid, busy, req_ready, grant_id);
        end else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        set_beat(0, 33'h1_0000_00B0);
        set_beat(1, 33'h1_0000_00B1);
        set_beat(3, 33'h1_0000_00B3);
        req_valid = 4'b1011;
        nrst      = 1'b1;
        sb.push_back(mk(33'h1_0000_00B0, 2'd0));
        @(negedge clk);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL mid_restart_ready: req_ready=%b expected 0001", req_ready);
        end else n_pass++;
        @(negedge clk);
        n_checks++;
        e = sb.pop_front();
        if (out_valid !== 1'b1 || out_data !== e.data || grant_id !== e.id) begin
            $display("FAIL mid_restart_beat: valid=%b data=%h id=%0d expected 1/%h/%0d",
                     out_valid, out_data, grant_id, e.data, e.id);
        end else n_pass++;
        @(posedge clk);
        #1 req_valid = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        nrst      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_contention();
        test_backpressure();
        test_rr_skip();
        test_lock();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
